// File: rtl/feistel_decrypt_if.sv
// ============================================================================
// Module      : feistel_decrypt_if
// Description : Command/result and dual SRAM port bundle for feistel_decrypt.
//               The abort input exists only with FEISTEL_DEC_ABORT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface feistel_decrypt_if;
    logic        start;
    logic [31:0] L;
    logic [31:0] R;
`ifdef FEISTEL_DEC_ABORT_EN
    logic        abort;
`endif

    logic [11:0] addr_a;
    logic [31:0] data_a;
    logic        cs_a_l;
    logic        we_a_l;
    logic        oe_a_l;

    logic [11:0] addr_b;
    logic [31:0] data_b;
    logic        cs_b_l;
    logic        we_b_l;
    logic        oe_b_l;

    logic [31:0] resultL;
    logic [31:0] resultR;
    logic        done;
    logic        busy;

    // Decryptor side.
    modport slave (
`ifdef FEISTEL_DEC_ABORT_EN
        input  abort,
`endif
        input  start, L, R, data_a, data_b,
        output addr_a, cs_a_l, we_a_l, oe_a_l,
        output addr_b, cs_b_l, we_b_l, oe_b_l,
        output resultL, resultR, done, busy
    );

    // Requester plus SRAM side.
    modport master (
`ifdef FEISTEL_DEC_ABORT_EN
        output abort,
`endif
        output start, L, R, data_a, data_b,
        input  addr_a, cs_a_l, we_a_l, oe_a_l,
        input  addr_b, cs_b_l, we_b_l, oe_b_l,
        input  resultL, resultR, done, busy
    );
endinterface

`default_nettype wire

// File: rtl/feistel_decrypt.sv
// ============================================================================
// Module      : feistel_decrypt
// Description : Blowfish block decryptor, 16 rounds on shared S-box/P-array
//               SRAMs, 3 cycles per round. Optional abort: FEISTEL_DEC_ABORT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module feistel_decrypt #(
    parameter int P_ARRAY_OFFSET = 4000
) (
    input  logic             clk,
    input  logic             reset_l,
    feistel_decrypt_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RND_A = 3'd1,
        RND_B = 3'd2,
        RND_C = 3'd3,
        FINAL = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [11:0] C_P_BASE      = 12'(P_ARRAY_OFFSET);
    localparam logic [11:0] C_S1_BASE     = 12'd256;
    localparam logic [11:0] C_S2_BASE     = 12'd512;
    localparam logic [11:0] C_S3_BASE     = 12'd768;
    localparam logic [4:0]  C_FIRST_ROUND = 5'd17;
    localparam logic [4:0]  C_LAST_ROUND  = 5'd2;

    state_t      state_q, state_d;
    logic [31:0] l_q, l_d;
    logic [31:0] r_q, r_d;
    logic [31:0] f_q, f_d;
    logic [4:0]  round_q, round_d;
    logic [31:0] result_l_q, result_l_d;
    logic [31:0] result_r_q, result_r_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;

    logic [31:0] w_lx;
    logic        w_abort;
    logic [11:0] w_addr_a;
    logic [11:0] w_addr_b;
    logic        w_cs_a_l;
    logic        w_cs_b_l;

`ifdef FEISTEL_DEC_ABORT_EN
    assign w_abort = bus.abort;
`else
    assign w_abort = 1'b0;
`endif

    // Left half after P-whitening; it also indexes S0/S1 in the same cycle.
    assign w_lx = l_q ^ bus.data_a;

    always_comb begin
        state_d    = state_q;
        l_d        = l_q;
        r_d        = r_q;
        f_d        = f_q;
        round_d    = round_q;
        result_l_d = result_l_q;
        result_r_d = result_r_q;
        done_d     = 1'b0;
        w_addr_a   = 12'd0;
        w_addr_b   = 12'd0;
        w_cs_a_l   = 1'b1;
        w_cs_b_l   = 1'b1;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    l_d      = bus.L;
                    r_d      = bus.R;
                    round_d  = C_FIRST_ROUND;
                    w_addr_a = C_P_BASE + {7'd0, C_FIRST_ROUND};
                    w_cs_a_l = 1'b0;
                    state_d  = RND_A;
                end
            end
            RND_A: begin
                l_d      = w_lx;
                w_addr_a = {4'd0, w_lx[31:24]};
                w_addr_b = C_S1_BASE + {4'd0, w_lx[23:16]};
                w_cs_a_l = 1'b0;
                w_cs_b_l = 1'b0;
                state_d  = RND_B;
            end
            RND_B: begin
                f_d      = bus.data_a + bus.data_b;
                w_addr_a = C_S2_BASE + {4'd0, l_q[15:8]};
                w_addr_b = C_S3_BASE + {4'd0, l_q[7:0]};
                w_cs_a_l = 1'b0;
                w_cs_b_l = 1'b0;
                state_d  = RND_C;
            end
            RND_C: begin
                // Round function completes and the halves swap in one step.
                l_d = r_q ^ ((f_q ^ bus.data_a) + bus.data_b);
                r_d = l_q;
                if (round_q > C_LAST_ROUND) begin
                    round_d  = round_q - 5'd1;
                    w_addr_a = C_P_BASE + {7'd0, round_q} - 12'd1;
                    w_cs_a_l = 1'b0;
                    state_d  = RND_A;
                end else begin
                    w_addr_a = C_P_BASE + 12'd1;
                    w_addr_b = C_P_BASE;
                    w_cs_a_l = 1'b0;
                    w_cs_b_l = 1'b0;
                    state_d  = FINAL;
                end
            end
            FINAL: begin
                // Crossing L/R here undoes the swap of the last round.
                result_r_d = l_q ^ bus.data_a;
                result_l_d = r_q ^ bus.data_b;
                done_d     = 1'b1;
                state_d    = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (w_abort && (state_q != IDLE)) begin
            state_d    = IDLE;
            result_l_d = result_l_q;
            result_r_d = result_r_q;
            done_d     = 1'b0;
            w_addr_a   = 12'd0;
            w_addr_b   = 12'd0;
            w_cs_a_l   = 1'b1;
            w_cs_b_l   = 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q    <= IDLE;
            l_q        <= 32'd0;
            r_q        <= 32'd0;
            f_q        <= 32'd0;
            round_q    <= 5'd0;
            result_l_q <= 32'd0;
            result_r_q <= 32'd0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            l_q        <= l_d;
            r_q        <= r_d;
            f_q        <= f_d;
            round_q    <= round_d;
            result_l_q <= result_l_d;
            result_r_q <= result_r_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.addr_a  = w_addr_a;
    assign bus.cs_a_l  = w_cs_a_l;
    assign bus.we_a_l  = 1'b1;
    assign bus.oe_a_l  = 1'b0;
    assign bus.addr_b  = w_addr_b;
    assign bus.cs_b_l  = w_cs_b_l;
    assign bus.we_b_l  = 1'b1;
    assign bus.oe_b_l  = 1'b0;
    assign bus.resultL = result_l_q;
    assign bus.resultR = result_r_q;
    assign bus.done    = done_q;
    assign bus.busy    = busy_q;

endmodule

`default_nettype wire
